// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of one shared combinational ROM; each read takes 3 cycles and ack follows the DONE state.
// Build with ROM_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties); the default is round-robin.
module rom_arbiter #(
  parameter int DW = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [7:0]    rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic          win_q;
  logic          win_d;
  logic          ack0_q;
  logic          ack1_q;
  logic          busy_q;
  logic [DW-1:0] rdata_q;
  logic [7:0]    rom_addr_q;

`ifdef ROM_ARB_FIXED_PRI_EN
  always_comb begin
    win_d = ~req0;
  end
`else
  logic last_grant_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win_d = req1;
    if (req0 && req1) begin
      win_d = ~last_grant_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (state_q == S_IDLE && (req0 || req1)) begin
      last_grant_q <= win_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      win_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      rom_addr_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            win_q      <= win_d;
            rom_addr_q <= win_d ? 8'(addr1) : 8'(addr0);
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rdata_q <= rom_data;
          state_q <= S_DONE;
        end
        S_DONE: begin
          // Ack is registered here, so it is visible in the cycle after DONE.
          ack0_q  <= ~win_q;
          ack1_q  <= win_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign rdata    = rdata_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter DW, default 4: ROM data width.
REQ-002 Parameter AW, default 3: requester address width; ROM depth 2^AW.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req0  in  1  requester 0 read request; held high until ack0.
REQ-006 addr0  in  AW  requester 0 address; stable while req0 high.
REQ-007 req1  in  1  requester 1 read request; held high until ack1.
REQ-008 addr1  in  AW  requester 1 address; stable while req1 high.
REQ-009 ack0  out  1  one-cycle pulse; rdata valid for requester 0.
REQ-010 ack1  out  1  one-cycle pulse; rdata valid for requester 1.
REQ-011 rdata  out  DW  registered read data; shared by both requesters.
REQ-012 rom_addr  out  8  address to shared ROM; granted addrN zero-extended.
REQ-013 rom_data  in  DW  ROM read data; combinational from rom_addr.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, ISSUE, DONE; exactly one active; unused encodings SHALL return to IDLE.
REQ-016 IDLE: no req -> stay; any req -> latch winner index and its address into rom_addr, go ISSUE.
REQ-017 ISSUE: capture rom_data into rdata at the edge, go DONE.
REQ-018 DONE: assert ackN for the latched winner only, for exactly one cycle; go IDLE.
REQ-019 Latency: req sampled high at edge N -> ack high in the cycle after edge N+2; one read per 3 cycles max.
REQ-020 Arbitration default round-robin: last_grant flop; on simultaneous req0 and req1, grant the requester not granted last.
REQ-021 last_grant updates only on the IDLE->ISSUE transition.
REQ-022 Single requester active: granted every time regardless of last_grant.
REQ-023 Requester whose req is still high in its DONE cycle SHALL NOT be re-granted from that same DONE cycle; re-arbitration happens only in IDLE.
REQ-024 rom_addr and rdata hold their last values in IDLE; rdata changes only on ISSUE->DONE.
REQ-025 req dropped before its ack (protocol violation): transaction still completes and ack still pulses.
REQ-026 ack0 and ack1 never high in the same cycle.

Reset
REQ-027 rst_n low forces immediately: state IDLE, ack0=0, ack1=0, busy=0, rdata=0, rom_addr=0, last_grant=1 (first tie goes to requester 0).
REQ-028 Reset mid-transaction aborts it; no ack issued for the aborted request after release.
REQ-029 First arbitration at the first rising edge with rst_n high.

Configuration
REQ-030 Macro ROM_ARB_FIXED_PRI_EN.
REQ-031 Defined: fixed priority, requester 0 always wins ties; last_grant flop removed.
REQ-032 Undefined: round-robin per REQ-020/021.
REQ-033 All other behaviour, latency and ports identical in both builds.

Verification
REQ-034 Reset, ROM[i]=2i; req0=1 addr0=3 -> rom_addr=3 during ISSUE, ack0 pulse 3 cycles after req, rdata=6.
REQ-035 req0 and req1 both high, addr0=1, addr1=5 (round-robin) -> ack0 rdata=2, then ack1 rdata=10; alternation continues while both held.
REQ-036 Same stimulus with ROM_ARB_FIXED_PRI_EN, req0 re-asserted immediately after each ack0 -> requester 0 served each time, ack1 never pulses.
REQ-037 rst_n low during ISSUE for req1 -> ack1 stays 0, rdata=0, busy=0 immediately; after release, held req1 re-served normally.
REQ-038 Only req1 high for 4 back-to-back reads, addr1=7 -> four ack1 pulses 3 cycles apart, rdata=14, ack0 always 0.
REQ-039 All runs: assert ack0&ack1 never high together and busy=0 only in IDLE.
